// File: rtl/pipe_stage_skid.sv
// Parametrised inter-stage pipeline register with a 2-entry skid buffer.
// in_ready/out_valid decode from the state register only, so no ready path crosses the stage.
module pipe_stage_skid #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] CLEAR_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]       state_p1;
    logic [WIDTH-1:0] main_p1;
    logic [WIDTH-1:0] skid_p1;

    logic             push;
    logic             pop;
    logic [1:0]       state_nxt;
    logic             load_main_in;
    logic             load_main_skid;
    logic             load_skid;

    assign out_valid = (state_p1 != EMPTY);
    assign in_ready  = (state_p1 != FULL);
    assign occupancy = state_p1;
    assign out_data  = main_p1;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_comb begin
        state_nxt      = state_p1;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_p1)
            EMPTY: begin
                if (push) begin
                    state_nxt    = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (push && pop) begin
                    load_main_in = 1'b1;
                end else if (push) begin
                    state_nxt = FULL;
                    load_skid = 1'b1;
                end else if (pop) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so only a pop can move the state
                if (pop) begin
                    state_nxt      = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
    end

    // stage p1: state, head and skid registers
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state_p1 <= EMPTY;
            main_p1  <= CLEAR_VALUE;
            skid_p1  <= CLEAR_VALUE;
        end else begin
            state_p1 <= state_nxt;
            if (load_main_in) begin
                main_p1 <= in_data;
            end else if (load_main_skid) begin
                main_p1 <= skid_p1;
            end
            if (load_skid) begin
                skid_p1 <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and soak checks for pipe_stage_skid (WIDTH=40, CLEAR_VALUE=40'hDEAD).
module tb_pipe_stage_skid;

    localparam int               W  = 40;
    localparam logic [W-1:0]     CV = 40'hDEAD;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic [1:0]   occupancy;

    int total = 0;
    int bad   = 0;

    pipe_stage_skid #(.WIDTH(W), .CLEAR_VALUE(CV)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", in_ready); end
        total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL reset_occ got=%0d want=0", occupancy); end
        total++; if (out_data !== CV) begin bad++; $display("FAIL reset_data got=%h want=%h", out_data, CV); end
    endtask

    task automatic test_stream();
        logic [W-1:0] vals [3];
        vals[0] = 40'h11; vals[1] = 40'h22; vals[2] = 40'h33;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = vals[i];
            tick();
            total++; if (out_data !== vals[i] || out_valid !== 1'b1) begin bad++; $display("FAIL stream_data[%0d] got=%h/%b want=%h/1", i, out_data, out_valid, vals[i]); end
            total++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin bad++; $display("FAIL stream_occ[%0d] got=%0d/%b want=1/1", i, occupancy, in_ready); end
        end
        in_valid = 1'b0;
        tick();
        total++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain got=%0d/%b want=0/0", occupancy, out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 40'hA0; tick();
        total++; if (occupancy !== 2'd1 || out_data !== 40'hA0) begin bad++; $display("FAIL bp_first got=%0d/%h want=1/a0", occupancy, out_data); end
        in_data = 40'hA1; tick();
        total++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin bad++; $display("FAIL bp_full got=%0d/%b want=2/0", occupancy, in_ready); end
        in_data = 40'hA2; tick();
        total++; if (occupancy !== 2'd2 || out_data !== 40'hA0) begin bad++; $display("FAIL bp_reject got=%0d/%h want=2/a0", occupancy, out_data); end
        out_ready = 1'b1; tick();
        total++; if (out_data !== 40'hA1 || occupancy !== 2'd1 || in_ready !== 1'b1) begin bad++; $display("FAIL bp_second got=%h/%0d/%b want=a1/1/1", out_data, occupancy, in_ready); end
        tick();
        total++; if (out_data !== 40'hA2 || occupancy !== 2'd1) begin bad++; $display("FAIL bp_third got=%h/%0d want=a2/1", out_data, occupancy); end
        in_valid = 1'b0; tick();
        total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL bp_empty got=%0d want=0", occupancy); end
    endtask

    task automatic fill_two(input logic [W-1:0] a, input logic [W-1:0] b);
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = a; tick();
        in_data = b; tick();
        in_valid = 1'b0;
    endtask

    task automatic test_drain();
        fill_two(40'hB0, 40'hB1);
        out_ready = 1'b1;
        total++; if (out_valid !== 1'b1 || out_data !== 40'hB0 || occupancy !== 2'd2) begin bad++; $display("FAIL drain0 got=%b/%h/%0d want=1/b0/2", out_valid, out_data, occupancy); end
        tick();
        total++; if (out_valid !== 1'b1 || out_data !== 40'hB1 || occupancy !== 2'd1) begin bad++; $display("FAIL drain1 got=%b/%h/%0d want=1/b1/1", out_valid, out_data, occupancy); end
        tick();
        total++; if (out_valid !== 1'b0 || out_data !== 40'hB1 || occupancy !== 2'd0) begin bad++; $display("FAIL drain2 got=%b/%h/%0d want=0/b1/0", out_valid, out_data, occupancy); end
        tick();
        total++; if (out_valid !== 1'b0 || out_data !== 40'hB1) begin bad++; $display("FAIL drain_retain got=%b/%h want=0/b1", out_valid, out_data); end
    endtask

    task automatic test_flush();
        fill_two(40'hC0, 40'hC1);
        flush = 1'b1; in_valid = 1'b1; in_data = 40'hC2; out_ready = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        total++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== CV || in_ready !== 1'b1) begin bad++; $display("FAIL flush_state got=%b/%0d/%h/%b want=0/0/dead/1", out_valid, occupancy, out_data, in_ready); end
        tick();
        total++; if (out_valid !== 1'b0 || out_data === 40'hC2) begin bad++; $display("FAIL flush_dropped got=%b/%h want=0/not c2", out_valid, out_data); end
        flush = 1'b1; in_valid = 1'b1; in_data = 40'hC3;
        tick(); tick();
        flush = 1'b0; in_valid = 1'b0;
        total++; if (occupancy !== 2'd0 || in_ready !== 1'b1 || out_data !== CV) begin bad++; $display("FAIL flush_held got=%0d/%b/%h want=0/1/dead", occupancy, in_ready, out_data); end
    endtask

    task automatic test_reset_priority();
        fill_two(40'hE0, 40'hE1);
        reset = 1'b1; flush = 1'b1; in_valid = 1'b1; in_data = 40'hE2; out_ready = 1'b1;
        tick();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
        total++; if (occupancy !== 2'd0 || out_data !== CV || out_valid !== 1'b0) begin bad++; $display("FAIL rstpri_state got=%0d/%h/%b want=0/dead/0", occupancy, out_data, out_valid); end
        in_valid = 1'b1; in_data = 40'hD0; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_data !== 40'hD0 || occupancy !== 2'd1) begin bad++; $display("FAIL rstpri_push got=%b/%h/%0d want=1/d0/1", out_valid, out_data, occupancy); end
        out_ready = 1'b1; tick();
    endtask

    task automatic test_soak();
        logic [W-1:0] q [$];
        logic [W-1:0] exp_main;
        logic         do_push, do_pop, do_flush;
        int           nbad = 0;
        exp_main = out_data === 40'hD0 ? 40'hD0 : CV;
        q.delete();
        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 1) == 1);
            flush     = ($urandom_range(0, 9) == 0);
            in_data   = {$urandom(), $urandom()};
            do_push   = in_valid && (q.size() < 2);
            do_pop    = out_ready && (q.size() > 0);
            do_flush  = flush;
            tick();
            if (do_flush) begin
                q.delete();
                exp_main = CV;
            end else begin
                if (do_pop) void'(q.pop_front());
                if (do_push) q.push_back(in_data);
                if (q.size() > 0) exp_main = q[0];
            end
            total++;
            if (occupancy !== q.size() || out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2) || out_data !== exp_main) begin
                bad++;
                if (nbad < 10) $display("FAIL soak[%0d] got=%0d/%b/%b/%h want=%0d/%h", c, occupancy, out_valid, in_ready, out_data, q.size(), exp_main);
                nbad++;
            end
        end
        flush = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_drain();
        test_flush();
        test_reset_priority();
        test_soak();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
